// File: rtl/amp_pkg.sv
// amp_pkg: shared width defaults, request/response record types and helpers for amplifier_mc
package amp_pkg;
   localparam int AMP_CH_NUM       = 4;
   localparam int AMP_ID_WIDTH     = 8;
   localparam int AMP_BASE_WIDTH   = 8;
   localparam int AMP_SCALER_WIDTH = 16;
   localparam int AMP_RES_WIDTH    = 16;
   localparam int AMP_FIFO_DEPTH   = 4;

   function automatic int ch_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

   localparam int AMP_CH_W = ch_w(AMP_CH_NUM);

   typedef struct packed {
      logic [AMP_ID_WIDTH-1:0]     id;
      logic [AMP_BASE_WIDTH-1:0]   base;
      logic [AMP_CH_W-1:0]         ch;
      logic [AMP_SCALER_WIDTH-1:0] scaler;
   } amp_req_t;

   typedef struct packed {
      logic [AMP_ID_WIDTH-1:0]  id;
      logic [AMP_RES_WIDTH-1:0] result;
      logic [AMP_CH_W-1:0]      ch;
      logic                     sat;
   } amp_rsp_t;
endpackage

// File: rtl/amp_fifo.sv
// amp_fifo: synchronous show-ahead FIFO of response records
//   clk/rst_n : clock, async active-low reset of pointers and count
//   push/din  : enqueue (ignored when full unless a pop frees a slot)
//   pop/dout  : dequeue, dout always shows the head
//   count/empty/full : occupancy status
module amp_fifo
   import amp_pkg::*;
#(
   parameter type T = amp_rsp_t,
   parameter int DEPTH = AMP_FIFO_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  T              din,
   input  logic          pop,
   output T              dout,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);
   T mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_pop, do_push;

   assign empty   = count == '0;
   assign full    = count == CW'(DEPTH);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rp];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end

   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/amplifier_mc.sv
// amplifier_mc: multi-channel pipelined scaler multiplier with credit-controlled output FIFO
//   write side : wr_en_i, set_scaler_i, wr_ch_i, wr_data_i, wr_rdy_o
//   read side  : rd_val_o, rd_rdy_i, rd_data_o {id,result}, rd_ch_o, rd_sat_o
//   scaler_o   : all scaler registers, channel k at [k*SCALER_WIDTH +: SCALER_WIDTH]
//   AMP_SAT_EN : when defined, results saturate to all-ones and flag rd_sat_o; otherwise they wrap
module amplifier_mc
   import amp_pkg::*;
#(
   parameter int CH_NUM       = AMP_CH_NUM,
   parameter int ID_WIDTH     = AMP_ID_WIDTH,
   parameter int BASE_WIDTH   = AMP_BASE_WIDTH,
   parameter int SCALER_WIDTH = AMP_SCALER_WIDTH,
   parameter int RES_WIDTH    = AMP_RES_WIDTH,
   parameter int FIFO_DEPTH   = AMP_FIFO_DEPTH,
   localparam int CH_W = ch_w(CH_NUM),
   localparam int DW   = ID_WIDTH + BASE_WIDTH,
   localparam int PW   = BASE_WIDTH + SCALER_WIDTH,
   localparam int CW   = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic                           wr_en_i,
   input  logic                           set_scaler_i,
   input  logic [CH_W-1:0]                wr_ch_i,
   input  logic [DW-1:0]                  wr_data_i,
   output logic                           wr_rdy_o,
   output logic                           rd_val_o,
   input  logic                           rd_rdy_i,
   output logic [ID_WIDTH+RES_WIDTH-1:0]  rd_data_o,
   output logic [CH_W-1:0]                rd_ch_o,
   output logic                           rd_sat_o,
   output logic [CH_NUM*SCALER_WIDTH-1:0] scaler_o
);
   typedef struct packed {
      logic [ID_WIDTH-1:0]     id;
      logic [BASE_WIDTH-1:0]   base;
      logic [CH_W-1:0]         ch;
      logic [SCALER_WIDTH-1:0] scaler;
   } req_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0]  id;
      logic [RES_WIDTH-1:0] result;
      logic [CH_W-1:0]      ch;
      logic                 sat;
   } rsp_t;

   logic [CH_NUM-1:0][SCALER_WIDTH-1:0] scaler;
   req_t s1;
   rsp_t s2, head;
   logic s1_v, s2_v, ch_ok, accept, empty, full;
   logic [CW-1:0] count;
   logic [PW-1:0] prod;
   logic [RES_WIDTH-1:0] res;
   logic sat;

   assign ch_ok    = 32'(wr_ch_i) < CH_NUM;
   // Credits cover FIFO entries plus both pipeline stages, so a push never meets a full FIFO.
   assign wr_rdy_o = ~full && (32'(count) + 32'(s1_v) + 32'(s2_v)) < FIFO_DEPTH;
   assign accept   = wr_en_i & ~set_scaler_i & wr_rdy_o;
   assign scaler_o = scaler;

   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) scaler <= '0;
      else if (wr_en_i && set_scaler_i && ch_ok) scaler[wr_ch_i] <= wr_data_i[SCALER_WIDTH-1:0];

   // The scaler is snapshotted here so later scaler writes cannot affect this item.
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         s1_v <= 1'b0;
         s1   <= '0;
      end else begin
         s1_v <= accept;
         if (accept) s1 <= '{id: wr_data_i[DW-1 -: ID_WIDTH], base: wr_data_i[BASE_WIDTH-1:0],
                             ch: wr_ch_i, scaler: ch_ok ? scaler[wr_ch_i] : '0};
      end

   assign prod = PW'(s1.base) * PW'(s1.scaler);
`ifdef AMP_SAT_EN
   assign sat = (prod >> RES_WIDTH) != '0;
   assign res = sat ? '1 : RES_WIDTH'(prod);
`else
   assign sat = 1'b0;
   assign res = RES_WIDTH'(prod);
`endif

   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         s2_v <= 1'b0;
         s2   <= '0;
      end else begin
         s2_v <= s1_v;
         if (s1_v) s2 <= '{id: s1.id, result: res, ch: s1.ch, sat: sat};
      end

   amp_fifo #(.T(rsp_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .push  (s2_v),
      .din   (s2),
      .pop   (rd_rdy_i),
      .dout  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   // Outputs are forced to zero when empty so uninitialised storage never shows.
   assign rd_val_o  = ~empty;
   assign rd_data_o = empty ? '0 : {head.id, head.result};
   assign rd_ch_o   = empty ? '0 : head.ch;
   assign rd_sat_o  = ~empty & head.sat;
endmodule

// File: tb/tb_amplifier_mc.sv
// tb_amplifier_mc: self-checking bench for amplifier_mc (directed table, corner sequences, random vs model)
module tb_amplifier_mc;
`ifdef AMP_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0, rstn = 1'b0;
   logic wr_en = 1'b0, set_scaler = 1'b0, rd_rdy = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [15:0] wr_data = '0;
   logic wr_rdy, rd_val, rd_sat;
   logic [23:0] rd_data;
   logic [1:0] rd_ch;
   logic [63:0] scaler_o;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   amplifier_mc dut (
      .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .set_scaler_i(set_scaler),
      .wr_ch_i(wr_ch), .wr_data_i(wr_data), .wr_rdy_o(wr_rdy), .rd_val_o(rd_val),
      .rd_rdy_i(rd_rdy), .rd_data_o(rd_data), .rd_ch_o(rd_ch), .rd_sat_o(rd_sat),
      .scaler_o(scaler_o)
   );

   typedef struct {
      logic [1:0] ch;
      logic [15:0] sc;
      logic [7:0] id;
      logic [7:0] base;
      logic [15:0] res;
      logic sat;
   } vec_t;

   typedef struct {
      logic [23:0] data;
      logic [1:0] ch;
      logic sat;
   } exp_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic set, input logic [1:0] ch, input logic [15:0] d);
      wr_en = en;
      set_scaler = set;
      wr_ch = ch;
      wr_data = d;
   endtask

   // Reference: full-precision product, then saturate or wrap to 16 bits.
   function automatic logic [16:0] ref_amp(input logic [7:0] base, input logic [15:0] sc);
      longint unsigned p = longint'(base) * longint'(sc);
      if (SAT && p > 65535) return {1'b1, 16'hFFFF};
      return {1'b0, 16'(p % 65536)};
   endfunction

   vec_t vt[7];
   exp_t q[$];
   logic [15:0] msc[4];

   function automatic logic [63:0] pack_sc();
      logic [63:0] p;
      for (int k = 0; k < 4; k++) p[k*16 +: 16] = msc[k];
      return p;
   endfunction

   initial begin
      int acc, outstanding, guard;
      logic exp_rdy, en, set;
      logic [16:0] r;
      exp_t e;
      vt[0] = '{2'd1, 16'd100,   8'd5,  8'd25,  16'd2500, 1'b0};
      vt[1] = '{2'd2, 16'd1000,  8'd6,  8'd200, SAT ? 16'hFFFF : 16'd3392, SAT};
      vt[2] = '{2'd3, 16'd257,   8'd7,  8'd255, 16'd65535, 1'b0};
      vt[3] = '{2'd0, 16'd65535, 8'd8,  8'd255, SAT ? 16'hFFFF : 16'd65281, SAT};
      vt[4] = '{2'd0, 16'd0,     8'd9,  8'd255, 16'd0, 1'b0};
      vt[5] = '{2'd1, 16'd65535, 8'd10, 8'd1,   16'd65535, 1'b0};
      vt[6] = '{2'd2, 16'd258,   8'd11, 8'd255, SAT ? 16'hFFFF : 16'd254, SAT};

      cyc();
      cyc();
      check("reset_rd_val_low", rd_val, 0);
      rstn = 1'b1;
      cyc();
      check("reset_rd_val", rd_val, 0);
      check("reset_rd_data", rd_data, 0);
      check("reset_rd_ch", rd_ch, 0);
      check("reset_rd_sat", rd_sat, 0);
      check("reset_scaler", scaler_o, 0);
      check("reset_wr_rdy", wr_rdy, 1);

      foreach (vt[i]) begin
         drive(1, 1, vt[i].ch, vt[i].sc);
         cyc();
         drive(1, 0, vt[i].ch, {vt[i].id, vt[i].base});
         check("vec_wr_rdy", wr_rdy, 1);
         cyc();
         drive(0, 0, 0, 0);
         check("vec_lat1", rd_val, 0);
         cyc();
         check("vec_lat2", rd_val, 0);
         cyc();
         check("vec_val", rd_val, 1);
         check("vec_data", rd_data, {vt[i].id, vt[i].res});
         check("vec_ch", rd_ch, vt[i].ch);
         check("vec_sat", rd_sat, vt[i].sat);
         rd_rdy = 1'b1;
         cyc();
         rd_rdy = 1'b0;
         check("vec_popped", rd_val, 0);
      end

      drive(1, 1, 0, 16'd2);
      cyc();
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, {8'(i), 8'(i + 1)});
         check("bp_wr_rdy", wr_rdy, i < 4);
         if (wr_rdy) acc++;
         cyc();
      end
      drive(0, 0, 0, 0);
      check("bp_accepted", acc, 4);
      check("bp_rdy_after", wr_rdy, 0);
      cyc();
      check("bp_held_data", rd_data, {8'd0, 16'd2});
      rd_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("bp_val", rd_val, 1);
         check("bp_data", rd_data, {8'(k), 16'(2 * (k + 1))});
         cyc();
      end
      rd_rdy = 1'b0;
      check("bp_empty", rd_val, 0);
      check("bp_rdy_back", wr_rdy, 1);

      drive(1, 1, 0, 16'd3);
      cyc();
      drive(1, 0, 0, {8'd20, 8'd7});
      cyc();
      drive(1, 1, 0, 16'd5);
      cyc();
      drive(0, 0, 0, 0);
      check("hz_scaler", scaler_o[15:0], 5);
      cyc();
      check("hz_val", rd_val, 1);
      check("hz_data", rd_data, {8'd20, 16'd21});
      rd_rdy = 1'b1;
      drive(1, 0, 0, {8'd21, 8'd7});
      cyc();
      rd_rdy = 1'b0;
      drive(0, 0, 0, 0);
      cyc();
      cyc();
      check("hz_data2", rd_data, {8'd21, 16'd35});
      rd_rdy = 1'b1;
      cyc();
      rd_rdy = 1'b0;

      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, {8'(40 + i), 8'd1});
         cyc();
      end
      drive(0, 0, 0, 0);
      cyc();
      check("mr_queued", rd_val, 1);
      rstn = 1'b0;
      #1;
      check("mr_val_async", rd_val, 0);
      check("mr_rdy_async", wr_rdy, 1);
      cyc();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("mr_no_stale", rd_val, 0);
      end
      check("mr_scaler", scaler_o, 0);

      foreach (msc[k]) msc[k] = '0;
      outstanding = 0;
      for (int c = 0; c < 3000; c++) begin
         check("rnd_scaler", scaler_o, pack_sc());
         exp_rdy = outstanding < 4;
         check("rnd_wr_rdy", wr_rdy, exp_rdy);
         en = $urandom_range(0, 9) < 7;
         set = $urandom_range(0, 4) == 0;
         drive(en, set, 2'($urandom_range(0, 3)),
               set && $urandom_range(0, 1) == 1 ? 16'($urandom_range(0, 300)) : 16'($urandom));
         rd_rdy = $urandom_range(0, 9) < 6;
         if (rd_val && rd_rdy) begin
            if (q.size() == 0) check("rnd_spurious", rd_val, 0);
            else begin
               e = q.pop_front();
               check("rnd_data", rd_data, e.data);
               check("rnd_ch", rd_ch, e.ch);
               check("rnd_sat", rd_sat, e.sat);
               outstanding--;
            end
         end
         if (en && !set && exp_rdy) begin
            r = ref_amp(wr_data[7:0], msc[wr_ch]);
            q.push_back('{{wr_data[15:8], r[15:0]}, wr_ch, r[16]});
            outstanding++;
         end
         if (en && set) msc[wr_ch] = wr_data;
         cyc();
      end
      drive(0, 0, 0, 0);
      rd_rdy = 1'b1;
      guard = 0;
      while (q.size() > 0 && guard < 40) begin
         if (rd_val) begin
            e = q.pop_front();
            check("drain_data", rd_data, e.data);
            check("drain_ch", rd_ch, e.ch);
            check("drain_sat", rd_sat, e.sat);
         end
         cyc();
         guard++;
      end
      check("drain_left", q.size(), 0);
      check("drain_empty", rd_val, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/amplifier_mc.md
# amplifier_mc

Multi-channel, pipelined successor of the single-channel amplifier. It holds one scaler register per channel and multiplies each incoming base number by its channel's scaler. Results, optionally saturated, are queued in an output FIFO with valid/ready backpressure. It sits between the command source, which writes scalers and base numbers, and the result consumer.

## Interface
- CH_NUM, 4: number of channels; ≥1; CH_W = max(1, $clog2(CH_NUM)).
- ID_WIDTH, 8: width of the sequence-number field carried through.
- BASE_WIDTH, 8: unsigned base-number width.
- SCALER_WIDTH, 16: unsigned scaler width; must be ≤ ID_WIDTH+BASE_WIDTH.
- RES_WIDTH, 16: result field width.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  write strobe.
- set_scaler_i  in  1  1 = scaler write, 0 = data write.
- wr_ch_i  in  CH_W  target channel.
- wr_data_i  in  ID_WIDTH+BASE_WIDTH  carries the scaler in its low SCALER_WIDTH bits for a scaler write, or {id, base} for a data write.
- wr_rdy_o  out  1  data write may be accepted this cycle.
- rd_val_o  out  1  FIFO head valid.
- rd_rdy_i  in  1  consumer accepts the head.
- rd_data_o  out  ID_WIDTH+RES_WIDTH  {id, result}.
- rd_ch_o  out  CH_W  channel of the head entry.
- rd_sat_o  out  1  the head result was saturated.
- scaler_o  out  CH_NUM*SCALER_WIDTH  all scaler registers; channel k occupies bits [k*SCALER_WIDTH +: SCALER_WIDTH].

## Operation
- Scaler write: wr_en_i=1 and set_scaler_i=1. Always accepted and ignores wr_rdy_o. Updates scaler[wr_ch_i] at that edge. Produces no output. Ignored if wr_ch_i ≥ CH_NUM.
- Data write: wr_en_i=1, set_scaler_i=0 and wr_rdy_o=1. When wr_rdy_o=0 the write is dropped; the upstream must hold it until wr_rdy_o=1.
- On acceptance, stage 1 captures id, base, channel and the scaler value present that cycle. A scaler change made afterwards does not affect an in-flight item.
- Stage 2 computes the product = base × scaler, unsigned, BASE_WIDTH+SCALER_WIDTH bits. It reduces the product to RES_WIDTH (see Configuration) and pushes {id, result}, the channel and the sat flag into the FIFO.
- If wr_ch_i ≥ CH_NUM on a data write, the scaler is taken as 0, giving result 0.
- Credit rule: wr_rdy_o = (FIFO occupancy + items in stages 1–2) < FIFO_DEPTH. The FIFO therefore never overflows, and no stall signal is needed inside the pipeline.
- The FIFO is show-ahead. A pop happens when rd_val_o=1 and rd_rdy_i=1. Output order equals acceptance order across all channels.
- A pop and a credit-consuming acceptance may occur in the same cycle. The count is updated by +1−1.
- Reset clears the pipeline valids, the FIFO pointers and count, and all scalers to 0. A reset mid-operation discards all queued and in-flight results.

## Timing
- Reset values: rd_val_o=0, rd_data_o=0, rd_ch_o=0, rd_sat_o=0, scaler_o=0, wr_rdy_o=1.
- A scaler written at edge N is used by a data write accepted at edge N+1.
- Latency: a data write accepted at edge N gives rd_val_o=1 after edge N+2, provided the FIFO was empty.
- Throughput: one data write per cycle while rd_rdy_i=1.
- wr_rdy_o is a combinational function of registers only. It has no path from wr_en_i or rd_rdy_i.
- The rd_* outputs are held stable while rd_val_o=1 and rd_rdy_i=0.

## Configuration
- AMP_SAT_EN defined:
  - If the product ≥ 2^RES_WIDTH, the result is 2^RES_WIDTH−1 and rd_sat_o=1.
  - Otherwise the result is the exact product and rd_sat_o=0.
- AMP_SAT_EN undefined:
  - The result is the low RES_WIDTH bits of the product (wrap-around).
  - rd_sat_o is tied to 0.

## Structure
- Package amp_pkg holds:
  - default width constants;
  - typedef amp_req_t {id, base, ch, scaler};
  - typedef amp_rsp_t {id, result, ch, sat}.
- One sub-module, amp_fifo: a parametrised synchronous show-ahead FIFO of amp_rsp_t with push, pop, count, empty and full.
- Scaler registers, the two pipeline stages and the credit logic live in amplifier_mc.

## Test plan
- Reset: rstn_i=0 for 2 cycles, then release → rd_val_o=0, scaler_o=0, wr_rdy_o=1.
- Basic: write scaler ch1=100, then data ch1 {8'd5, 8'd25} → two edges after acceptance: rd_val_o=1, rd_data_o={8'd5, 16'd2500}, rd_ch_o=1, rd_sat_o=0.
- Saturation: write scaler ch2=1000, then data base=200 (product 200000):
  - with AMP_SAT_EN → result 16'hFFFF, rd_sat_o=1;
  - without → result 3392, rd_sat_o=0.
- Backpressure: hold rd_rdy_i=0 and attempt 6 back-to-back data writes → exactly 4 accepted and wr_rdy_o=0 after the 4th. Then set rd_rdy_i=1 → 4 results are popped in order with ids 0..3.
- Scaler hazard: write scaler ch0=3, next cycle data ch0 base=7, next cycle scaler ch0=5 → result 21, and scaler_o ch0 field=5. A following data write with base=7 → 35.
- Reset mid-stream: with 3 entries queued and 1 in flight, assert rstn_i=0 → rd_val_o=0 immediately. After release, no stale result appears and all scalers read 0.
